// File: rtl/mips_cpu_cache_wbuf_coalesce_if.sv
// Bus bundle between the data cache and the coalescing write buffer.
// Groups the push, lookup, drain and Avalon-MM write signals plus occupancy status.
//   slave  : used by the write buffer (push/lookup/drain inputs, Avalon and status outputs)
//   master : used by the cache side (drives push/lookup/drain/waitrequest, observes the rest)
interface mips_cpu_cache_wbuf_coalesce_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 3
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_W-1:0]     push_addr;
  logic [DATA_W-1:0]     push_data;
  logic [BE_W-1:0]       push_be;

  logic [ADDR_W-1:0]     lookup_addr;
  logic                  lookup_hit;
  logic [DATA_W-1:0]     lookup_data;
  logic [BE_W-1:0]       lookup_be;

  logic                  drain_en;
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [BE_W-1:0]       avm_byteenable;
  logic                  avm_waitrequest;

  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;

  modport slave (
    input  push_valid, push_addr, push_data, push_be, lookup_addr, drain_en, avm_waitrequest,
    output push_ready, lookup_hit, lookup_data, lookup_be,
    output avm_address, avm_write, avm_writedata, avm_byteenable, count, full, empty
  );

  modport master (
    output push_valid, push_addr, push_data, push_be, lookup_addr, drain_en, avm_waitrequest,
    input  push_ready, lookup_hit, lookup_data, lookup_be,
    input  avm_address, avm_write, avm_writedata, avm_byteenable, count, full, empty
  );
endinterface

// File: rtl/mips_cpu_cache_wbuf_coalesce.sv
// Coalescing write buffer between the data cache and the Avalon-MM memory port.
// Posted word writes are queued in a circular buffer and retired in FIFO order; pushes to a
// word already queued (and not in flight) merge into the youngest such entry. A combinational
// lookup forwards pending store bytes so read misses can be serviced with stores outstanding.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; abandons any in-flight write
//   bus  - slave side of the bundle: push handshake, lookup, drain_en, Avalon write master,
//          count/full/empty status
module mips_cpu_cache_wbuf_coalesce #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned COALESCE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  mips_cpu_cache_wbuf_coalesce_if.slave   bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF   = $clog2(BE_W);
  localparam int unsigned WA_W  = ADDR_W - OFF;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [DEPTH-1:0]  valid_q;
  logic [WA_W-1:0]   waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  ptr_t              head_q, tail_q;
  cnt_t              count_q, count_d;
  logic [0:0]        state_q, state_d;

  ptr_t              age_idx [DEPTH];  // age_idx[0] is the head, higher k is younger
  logic [WA_W-1:0]   push_word, lookup_word;
  logic              in_flight, retire, full, empty;
  logic              coal_hit, push_ready, push_fire, push_new, push_merge;
  ptr_t              coal_idx;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [BE_W-1:0]   lookup_be;

  assign push_word   = bus.push_addr[ADDR_W-1:OFF];
  assign lookup_word = bus.lookup_addr[ADDR_W-1:OFF];
  assign in_flight   = (state_q == StIssue);
  assign retire      = in_flight && !bus.avm_waitrequest;
  assign full        = (count_q == cnt_t'(DEPTH));
  assign empty       = (count_q == '0);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k] = head_q + ptr_t'(k);
    end
  end

  // Youngest matching entry wins; the head is off limits while its data is on the bus.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    if (COALESCE != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (valid_q[age_idx[k]] && (waddr_q[age_idx[k]] == push_word) &&
            !((k == 0) && in_flight)) begin
          coal_hit = 1'b1;
          coal_idx = age_idx[k];
        end
      end
    end
  end

  assign push_ready = !full || coal_hit;
  assign push_fire  = bus.push_valid && push_ready;
  assign push_merge = push_fire && coal_hit;
  assign push_new   = push_fire && !coal_hit;

  // Walk oldest to youngest so younger bytes overwrite older ones lane by lane.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_be   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[age_idx[k]] && (waddr_q[age_idx[k]] == lookup_word)) begin
        lookup_hit = 1'b1;
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[age_idx[k]][b]) begin
            lookup_data[8*b +: 8] = data_q[age_idx[k]][8*b +: 8];
            lookup_be[b]          = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_new && !retire) begin
      count_d = count_q + cnt_t'(1);
    end else if (!push_new && retire) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  // drain_en is only consulted between transfers; once issued the write runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!empty && bus.drain_en) state_d = StIssue;
      StIssue: if (!bus.avm_waitrequest) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (retire) begin
        head_q          <= head_q + ptr_t'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (push_new) begin
        tail_q          <= tail_q + ptr_t'(1);
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    if (push_new) begin
      waddr_q[tail_q] <= push_word;
      data_q[tail_q]  <= bus.push_data;
      be_q[tail_q]    <= bus.push_be;
    end else if (push_merge) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.push_be[b]) begin
          data_q[coal_idx][8*b +: 8] <= bus.push_data[8*b +: 8];
        end
      end
      be_q[coal_idx] <= be_q[coal_idx] | bus.push_be;
    end
  end

  assign bus.push_ready     = push_ready;
  assign bus.lookup_hit     = lookup_hit;
  assign bus.lookup_data    = lookup_data;
  assign bus.lookup_be      = lookup_be;
  assign bus.avm_write      = in_flight;
  assign bus.avm_address    = ADDR_W'(waddr_q[head_q]) << OFF;
  assign bus.avm_writedata  = data_q[head_q];
  assign bus.avm_byteenable = be_q[head_q];
  assign bus.count          = count_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
endmodule

// File: tb/tb_mips_cpu_cache_wbuf_coalesce.sv
// Self-checking bench for mips_cpu_cache_wbuf_coalesce: a merging instance (dut1) and a
// plain-FIFO instance (dut0) see identical stimulus. Lookups are checked from vector tables;
// memory writes retired by dut1 are checked against a queue of expected writes.
module tb_mips_cpu_cache_wbuf_coalesce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_cache_wbuf_coalesce_if bus1 ();
  mips_cpu_cache_wbuf_coalesce_if bus0 ();

  mips_cpu_cache_wbuf_coalesce #(.COALESCE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mips_cpu_cache_wbuf_coalesce #(.COALESCE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus0.push_valid      = bus1.push_valid;
  assign bus0.push_addr       = bus1.push_addr;
  assign bus0.push_data       = bus1.push_data;
  assign bus0.push_be         = bus1.push_be;
  assign bus0.lookup_addr     = bus1.lookup_addr;
  assign bus0.drain_en        = bus1.drain_en;
  assign bus0.avm_waitrequest = bus1.avm_waitrequest;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
    logic [3:0]  be;
  } lk_t;

  wr_t sb_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  n_retired = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus1.push_valid = 1'b1;
    bus1.push_addr  = a;
    bus1.push_data  = d;
    bus1.push_be    = be;
    tick();
    bus1.push_valid = 1'b0;
  endtask

  task automatic lookup_chk(input string nm, input lk_t v, input logic both);
    bus1.lookup_addr = v.addr;
    #1;
    check({nm, "_hit1"},  bus1.lookup_hit,  v.hit);
    check({nm, "_data1"}, bus1.lookup_data, v.data);
    check({nm, "_be1"},   bus1.lookup_be,   v.be);
    if (both) begin
      check({nm, "_hit0"},  bus0.lookup_hit,  v.hit);
      check({nm, "_data0"}, bus0.lookup_data, v.data);
      check({nm, "_be0"},   bus0.lookup_be,   v.be);
    end
  endtask

  task automatic wait_empty(input string nm);
    for (int c = 0; c < 300 && !bus1.empty; c++) tick();
    check({nm, "_drained"}, bus1.empty, 1'b1);
    check({nm, "_sb_left"}, sb_q.size(), 0);
  endtask

  // A write completes on the edge after a cycle with avm_write && !avm_waitrequest.
  always @(negedge clk) begin
    if (!rst && bus1.avm_write && !bus1.avm_waitrequest) begin
      n_retired++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", bus1.avm_address, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("sb_addr", bus1.avm_address,    e.addr);
        check("sb_data", bus1.avm_writedata,  e.data);
        check("sb_be",   bus1.avm_byteenable, e.be);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lk_t t3a [4];
    lk_t t3b [3];
    lk_t v;
    wr_t e;
    int  k;
    int  r0;
    logic acc;

    t3a[0] = '{addr: 32'h200, hit: 1'b1, data: 32'hAA00_3344, be: 4'hB};
    t3a[1] = '{addr: 32'h203, hit: 1'b1, data: 32'hAA00_3344, be: 4'hB};
    t3a[2] = '{addr: 32'h204, hit: 1'b0, data: 32'h0,         be: 4'h0};
    t3a[3] = '{addr: 32'h1FC, hit: 1'b0, data: 32'h0,         be: 4'h0};
    t3b[0] = '{addr: 32'h200, hit: 1'b1, data: 32'hAA00_3355, be: 4'hB};
    t3b[1] = '{addr: 32'h202, hit: 1'b1, data: 32'hAA00_3355, be: 4'hB};
    t3b[2] = '{addr: 32'h100, hit: 1'b0, data: 32'h0,         be: 4'h0};

    bus1.push_valid = 1'b0; bus1.push_addr = '0; bus1.push_data = '0; bus1.push_be = '0;
    bus1.lookup_addr = '0; bus1.drain_en = 1'b0; bus1.avm_waitrequest = 1'b0;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    check("rst_avm_write",  bus1.avm_write,   1'b0);
    check("rst_count",      bus1.count,       4'd0);
    check("rst_empty",      bus1.empty,       1'b1);
    check("rst_full",       bus1.full,        1'b0);
    check("rst_push_ready", bus1.push_ready,  1'b1);
    check("rst_lk_hit",     bus1.lookup_hit,  1'b0);
    check("rst_lk_be",      bus1.lookup_be,   4'h0);
    check("rst_lk_data",    bus1.lookup_data, 32'h0);

    // Single push, no drain
    do_push(32'h100, 32'hAABB_CCDD, 4'hF);
    sb_q.push_back('{addr: 32'h100, data: 32'hAABB_CCDD, be: 4'hF});
    check("t1_count", bus1.count,     4'd1);
    check("t1_empty", bus1.empty,     1'b0);
    check("t1_avm",   bus1.avm_write, 1'b0);
    v = '{addr: 32'h100, hit: 1'b1, data: 32'hAABB_CCDD, be: 4'hF};
    lookup_chk("t1_lk", v, 1'b1);

    // Stalled transfer: 3 waitrequest cycles then accept
    bus1.avm_waitrequest = 1'b1;
    bus1.drain_en = 1'b1;
    tick();
    bus1.drain_en = 1'b0;  // must not abort the issued write
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus1.avm_waitrequest = 1'b0;
      check("t2_avm_held", bus1.avm_write,   1'b1);
      check("t2_avm_addr", bus1.avm_address, 32'h100);
      check("t2_count",    bus1.count,       4'd1);
      tick();
    end
    check("t2_avm_done", bus1.avm_write, 1'b0);
    check("t2_count0",   bus1.count,     4'd0);
    check("t2_empty",    bus1.empty,     1'b1);
    check("t2_sb_left",  sb_q.size(),    0);

    // Coalescing vs plain FIFO
    do_reset();
    do_push(32'h200, 32'h1122_3344, 4'h3);
    do_push(32'h202, 32'hAA00_0000, 4'h8);
    check("t3_count_c1", bus1.count, 4'd1);
    check("t3_count_c0", bus0.count, 4'd2);
    for (int i = 0; i < 4; i++) lookup_chk($sformatf("t3a_%0d", i), t3a[i], 1'b1);
    do_push(32'h201, 32'h0000_0055, 4'h1);
    check("t3_count2_c1", bus1.count, 4'd1);
    check("t3_count2_c0", bus0.count, 4'd3);
    for (int i = 0; i < 3; i++) lookup_chk($sformatf("t3b_%0d", i), t3b[i], 1'b1);

    // Fill to full, reject a distinct push, merge into entry 3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_push(32'h1000 + 32'(4 * i), 32'(i), 4'hF);
      sb_q.push_back('{addr: 32'h1000 + 32'(4 * i), data: 32'(i), be: 4'hF});
    end
    check("t4_full",  bus1.full,  1'b1);
    check("t4_count", bus1.count, 4'd8);
    bus1.push_valid = 1'b1; bus1.push_addr = 32'h2000;
    bus1.push_data = 32'h9999_9999; bus1.push_be = 4'hF;
    #1;
    check("t4_ready_distinct", bus1.push_ready, 1'b0);
    tick();
    bus1.push_valid = 1'b0;
    check("t4_count_after_reject", bus1.count, 4'd8);
    v = '{addr: 32'h2000, hit: 1'b0, data: 32'h0, be: 4'h0};
    lookup_chk("t4_rejected", v, 1'b1);
    bus1.push_valid = 1'b1; bus1.push_addr = 32'h100C;
    bus1.push_data = 32'hDEAD_0000; bus1.push_be = 4'hC;
    #1;
    check("t4_ready_merge_c1", bus1.push_ready, 1'b1);
    check("t4_ready_merge_c0", bus0.push_ready, 1'b0);
    tick();
    bus1.push_valid = 1'b0;
    e = sb_q[3];
    e.data = 32'hDEAD_0003;
    sb_q[3] = e;
    check("t4_count_merge_c1", bus1.count, 4'd8);
    check("t4_count_merge_c0", bus0.count, 4'd8);
    v = '{addr: 32'h100C, hit: 1'b1, data: 32'hDEAD_0003, be: 4'hF};
    lookup_chk("t4_merged", v, 1'b0);

    // Drain with a new push per retire across pointer wrap
    bus1.avm_waitrequest = 1'b0;
    bus1.drain_en = 1'b1;
    k = 0;
    for (int g = 0; g < 500 && k < 20; g++) begin
      bus1.push_valid = 1'b1;
      bus1.push_addr  = 32'h3000 + 32'(4 * k);
      bus1.push_data  = 32'h5000_0000 + 32'(k);
      bus1.push_be    = 4'hF;
      #1;
      acc = bus1.push_ready;
      if (acc) sb_q.push_back('{addr: 32'h3000 + 32'(4 * k), data: 32'h5000_0000 + 32'(k),
                                be: 4'hF});
      check("t5_count_le_depth", 64'(bus1.count <= 4'd8), 1);
      tick();
      if (acc) k++;
    end
    bus1.push_valid = 1'b0;
    check("t5_pushes_done", k, 20);
    wait_empty("t5");

    // Reset during an in-flight write
    do_reset();
    bus1.drain_en = 1'b0;
    bus1.avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) do_push(32'h4000 + 32'(4 * i), 32'h7700 + 32'(i), 4'hF);
    bus1.drain_en = 1'b1;
    tick();
    check("t6_pre_avm",   bus1.avm_write, 1'b1);
    check("t6_pre_count", bus1.count,     4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("t6_avm",   bus1.avm_write, 1'b0);
    check("t6_count", bus1.count,     4'd0);
    v = '{addr: 32'h4000, hit: 1'b0, data: 32'h0, be: 4'h0};
    lookup_chk("t6_lk", v, 1'b1);
    bus1.avm_waitrequest = 1'b0;
    r0 = n_retired;
    do_push(32'h5000, 32'h1234_5678, 4'h6);
    sb_q.push_back('{addr: 32'h5000, data: 32'h1234_5678, be: 4'h6});
    check("t6_push_count", bus1.count, 4'd1);
    wait_empty("t6");
    check("t6_one_write", n_retired - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cpu_cache_wbuf_coalesce.md
Name: mips_cpu_cache_wbuf_coalesce

Overview:
Parametrised, coalescing write buffer between the data cache and the Avalon-MM memory port. It replaces the fixed 8-entry, 32-bit write buffer.
- Accepts posted word writes from the cache and retires them to memory in FIFO order.
- Merges repeated writes to the same word into one entry.
- Provides byte-granular store-to-load forwarding so the cache can service a read miss while stores are still pending.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; must be a multiple of 8; BE_W = DATA_W/8
DEPTH_LOG2, 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2
COALESCE, 1, 1 = merge pushes into matching queued entries; 0 = plain FIFO

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
push_valid  in  1  cache offers a write this cycle
push_ready  out  1  buffer can accept the offered write
push_addr  in  ADDR_W  byte address; low log2(BE_W) bits ignored
push_data  in  DATA_W  write data
push_be  in  BE_W  byte enables
lookup_addr  in  ADDR_W  read address to check against the buffer
lookup_hit  out  1  at least one valid entry matches lookup_addr
lookup_data  out  DATA_W  merged forwarded bytes; undefined bytes read 0
lookup_be  out  BE_W  OR of matching entries' byte enables
drain_en  in  1  permission to start a new memory write
avm_address  out  ADDR_W  head entry address, low bits zeroed
avm_write  out  1  Avalon write request
avm_writedata  out  DATA_W  head entry data
avm_byteenable  out  BE_W  head entry byte enables
avm_waitrequest  in  1  Avalon stall
count  out  DEPTH_LOG2+1  number of valid entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Storage is a circular queue: head (oldest), tail (next free), count. Pointers wrap modulo DEPTH. Per-entry valid, addr, data, be.
- Reset (synchronous) clears all of the following next edge: head, tail, count, every valid bit, and drain state.
  - Outputs after reset: avm_write=0, count=0, empty=1, full=0, push_ready=1, lookup_hit=0, lookup_be=0, lookup_data=0.
  - Reset mid-transfer abandons the in-flight write; avm_write is 0 the cycle after rst is sampled.
- Word match: compare addr[ADDR_W-1:log2(BE_W)] only.
- Push is accepted on an edge where push_valid && push_ready. It is one-shot per accepting cycle, with no edge detection; the cache must drop push_valid after acceptance.
- Coalesce (COALESCE=1):
  - Condition: push matches a valid entry that is not the head while avm_write=1.
  - Action: merge into the youngest such entry. Bytes with push_be set overwrite; be |= push_be.
  - count and tail are unchanged.
- Otherwise the push writes entry[tail], tail+1, count+1.
- push_ready = !full || coalesce_hit (combinational).
  - A full buffer still accepts merging pushes.
  - A retire in the same cycle does not raise push_ready.
- Drain FSM, 2 states:
  - IDLE: avm_write=0. Go to ISSUE when !empty && drain_en.
  - ISSUE: avm_write=1. Address, data and be come from entry[head]. These must stay stable until accepted, and drain_en is ignored while in ISSUE.
  - On avm_write && !avm_waitrequest: clear valid[head], head+1, count-1, and go to IDLE.
  - The next entry is issued no earlier than the following cycle (one bubble between writes).
  - Deasserting drain_en pauses draining only between transfers; the cache uses this to hijack the bus for read misses.
- Latency: an entry pushed at edge N can be presented on avm_write at earliest after edge N+1.
- Simultaneous push (new entry) and retire: count unchanged, head and tail both advance.
- Simultaneous push matching the in-flight head: treated as a new entry, so it requires !full.
- Lookup (combinational, no pipeline):
  - For each byte lane, forward the value from the youngest valid matching entry with that be bit set.
  - The head entry is included even while it is in flight.
  - Same-cycle push is not visible; it becomes visible the next cycle.
- Pointer wrap: correct across any number of wraps; full/empty are derived from count, not from pointer equality.
- count never exceeds DEPTH or underflows. Pushing while full without a coalesce match is ignored (push_ready=0).

Test Plan:
1. Reset, then push 0x100/0xAABBCCDD/be=F with drain_en=0 -> count=1, empty=0, avm_write=0; lookup 0x100 -> hit=1, data=0xAABBCCDD, be=F.
2. drain_en=1 with waitrequest high for 3 cycles, then low -> avm_write held 4 cycles with stable address 0x100; entry retired after the low cycle; count=0, empty=1, avm_write=0 next cycle.
3. COALESCE=1, drain_en=0: push 0x200/0x11223344/be=3, then 0x202/0xAA000000/be=8 -> count=1, lookup 0x200 data=0xAA003344, be=B. Repeat with COALESCE=0 -> count=2, same lookup result.
4. drain_en=0: push 8 distinct addresses -> full=1, push_ready=0. A 9th distinct push is ignored (count=8). A push matching entry 3 is accepted and merged (count=8).
5. Full buffer draining with waitrequest=0, plus one new push per retire, for 20 pushes -> avm_address order matches push order across pointer wrap; count stays at 8 or below, never overflows.
6. Assert rst while avm_write=1 and count=5 -> next cycle avm_write=0, count=0, lookup_hit=0; the next push lands at entry 0 and is issued normally.
